// File: rtl/pipe_reg_chain_pkg.sv
// pipe_reg_chain_pkg: shared sizing helper for the register pipeline
package pipe_reg_chain_pkg;

    // Width needed to represent an occupancy of 0..depth
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// pipe_stage: one valid/data register pair of the bubble-collapsing pipeline
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             pop,
    input  logic [WIDTH-1:0] src,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    assign rdy = ~v | pop;

    // Reset clears everything; flush only drops valid; a load wins over a pop
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (load) begin
            v <= 1'b1;
            d <= src;
        end else if (pop) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: bubble-collapsing valid/ready register pipeline with flush and occupancy count
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 3,
    parameter bit INVERT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [cw_of(DEPTH)-1:0]  count
);

    localparam int CW = cw_of(DEPTH);

    logic [DEPTH-1:0] vv;

    for (genvar i = 0; i < DEPTH; i++) begin : g
        logic             v, rdy, pop, load;
        logic [WIDTH-1:0] d, src;
        if (i == DEPTH - 1) begin : last
            assign pop = out_ready;
        end else begin : mid
            assign pop = g[i+1].load;
        end
        if (i == 0) begin : head
            assign load = in_valid & in_ready;
            assign src  = INVERT ? ~in_data : in_data;
        end else begin : body
            assign load = g[i-1].v & rdy;
            assign src  = g[i-1].d;
        end
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk  (clk),
            .reset(reset),
            .flush(flush),
            .load (load),
            .pop  (pop),
            .src  (src),
            .v    (v),
            .d    (d),
            .rdy  (rdy)
        );
        assign vv[i] = v;
    end

    assign in_ready  = g[0].rdy & ~flush;
    assign out_valid = g[DEPTH-1].v;
    assign out_data  = g[DEPTH-1].d;

    // Occupancy is the population count of the stage valid bits
    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) count = count + CW'(vv[k]);
    end

endmodule
